// File: rtl/barrett_reduce_pipe.sv
// Multi-lane pipelined Barrett reducer (C mod Q) with valid/ready flow control.
// Define BARRETT_MUL_EN to multiply operand pairs a*b in an extra front stage.
module barrett_reduce_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned Q     = 3329,
  parameter int unsigned K     = 26,
  parameter int unsigned LANES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [LANES*2*WIDTH-1:0] in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LANES*WIDTH-1:0]   out_data_o,
  output logic                     busy_o
);

  localparam int unsigned CW = 2 * WIDTH;
  localparam int unsigned PW = CW + K;
  localparam logic [PW-1:0] M   = PW'((64'd1 << K) / 64'(Q));
  localparam logic [CW-1:0] Q_C = CW'(Q);

  logic adv_c;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
`ifdef BARRETT_MUL_EN
  logic v0_q, v0_d;
`endif

  // Shared valid chain: every stage moves together when the output slot frees up.
  always_comb begin
    adv_c = ~v3_q | out_ready_i;
`ifdef BARRETT_MUL_EN
    v0_d  = v0_q;
`endif
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    if (adv_c) begin
`ifdef BARRETT_MUL_EN
      v0_d = in_valid_i;
      v1_d = v0_q;
`else
      v1_d = in_valid_i;
`endif
      v2_d = v1_q;
      v3_d = v2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef BARRETT_MUL_EN
      v0_q <= 1'b0;
`endif
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
`ifdef BARRETT_MUL_EN
      v0_q <= v0_d;
`endif
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  assign in_ready_o  = adv_c;
  assign out_valid_o = v3_q;
`ifdef BARRETT_MUL_EN
  assign busy_o      = v0_q | v1_q | v2_q | v3_q;
`else
  assign busy_o      = v1_q | v2_q | v3_q;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [CW-1:0]    c_in;
    logic [CW-1:0]    src;
    logic [CW-1:0]    c1_q, c1_d, c2_q, c2_d, t2_q, t2_d;
    logic [PW-1:0]    p1_q, p1_d;
    logic [CW-1:0]    r_c;
    logic [WIDTH-1:0] r3_q, r3_d;
`ifdef BARRETT_MUL_EN
    logic [CW-1:0]    c0_q, c0_d;
`endif

    assign c_in = in_data_i[i*CW +: CW];

    // Quotient estimate undershoots by at most one, so r lands in [0, 2Q).
    always_comb begin
`ifdef BARRETT_MUL_EN
      c0_d = c0_q;
      src  = c0_q;
`else
      src  = c_in;
`endif
      c1_d = c1_q;
      p1_d = p1_q;
      c2_d = c2_q;
      t2_d = t2_q;
      r3_d = r3_q;
      r_c  = c2_q - t2_q * Q_C;
      if (adv_c) begin
`ifdef BARRETT_MUL_EN
        c0_d = CW'(c_in[WIDTH-1:0]) * CW'(c_in[CW-1:WIDTH]);
`endif
        c1_d = src;
        p1_d = PW'(src) * M;
        c2_d = c1_q;
        t2_d = CW'(p1_q >> K);
        r3_d = (r_c >= Q_C) ? WIDTH'(r_c - Q_C) : WIDTH'(r_c);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef BARRETT_MUL_EN
        c0_q <= '0;
`endif
        c1_q <= '0;
        p1_q <= '0;
        c2_q <= '0;
        t2_q <= '0;
        r3_q <= '0;
      end else begin
`ifdef BARRETT_MUL_EN
        c0_q <= c0_d;
`endif
        c1_q <= c1_d;
        p1_q <= p1_d;
        c2_q <= c2_d;
        t2_q <= t2_d;
        r3_q <= r3_d;
      end
    end

    assign out_data_o[i*WIDTH +: WIDTH] = r3_q;
  end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed bench for barrett_reduce_pipe: vector table, streaming, stall and reset cases.
// Honours BARRETT_MUL_EN (operand-pair inputs, 4-cycle latency).
module tb_barrett_reduce_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned Q  = 3329;
  localparam int unsigned L  = 2;
  localparam int unsigned CW = 2 * W;
`ifdef BARRETT_MUL_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [L*CW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [L*W-1:0]  out_data;
  logic            busy;

  barrett_reduce_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] x0;
    logic [CW-1:0] x1;
    logic [W-1:0]  e0;
    logic [W-1:0]  e1;
  } vec_t;

  vec_t        tab[$];
  logic [CW-1:0] exp_q[$];
  int          acc_q[$];
  int          cyc;
  int          errors;
  int          checks;
  int          rx_cnt;
  bit          chk_lat;
  logic [L*W-1:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [CW-1:0] x);
`ifdef BARRETT_MUL_EN
    return W'((32'(x[W-1:0]) * 32'(x[CW-1:W])) % Q);
`else
    return W'(x % Q);
`endif
  endfunction

  // One clock: inputs are already driven just after a negedge.
  logic [CW-1:0] nxt_exp;
  task automatic tick();
    logic [CW-1:0] e;
    int a;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        rx_cnt++;
        check("lane0", 32'(out_data[W-1:0]), 32'(e[W-1:0]));
        check("lane1", 32'(out_data[2*W-1:W]), 32'(e[CW-1:W]));
        if (chk_lat) check("latency", 32'(cyc - a), 32'(LAT));
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(nxt_exp);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [CW-1:0] x0, input logic [CW-1:0] x1,
                      input logic [W-1:0] e0, input logic [W-1:0] e1);
    in_valid = 1'b1;
    in_data  = {x1, x0};
    nxt_exp  = {e1, e0};
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [CW-1:0] r0, r1;
    cyc = 0; errors = 0; checks = 0; rx_cnt = 0; chk_lat = 1'b1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; nxt_exp = '0;

`ifdef BARRETT_MUL_EN
    tab.push_back('{x0: {16'd3328, 16'd3328}, x1: {16'd200, 16'd17}, e0: 16'd1,    e1: 16'd71});
    tab.push_back('{x0: {16'd5, 16'd0},       x1: {16'd100, 16'd100}, e0: 16'd0,   e1: 16'd13});
    tab.push_back('{x0: {16'd1, 16'd3328},    x1: {16'd2, 16'd3000}, e0: 16'd3328, e1: 16'd2671});
`else
    tab.push_back('{x0: 32'd0,        x1: 32'd12345,    e0: 16'd0,    e1: 16'd2358});
    tab.push_back('{x0: 32'd11075584, x1: 32'd11078912, e0: 16'd1,    e1: 16'd0});
    tab.push_back('{x0: 32'd3329,     x1: 32'd3328,     e0: 16'd0,    e1: 16'd3328});
    tab.push_back('{x0: 32'd6657,     x1: 32'd11082240, e0: 16'd3328, e1: 16'd3328});
    tab.push_back('{x0: 32'd65535,    x1: 32'd1000000,  e0: 16'd2284, e1: 16'd1300});
    tab.push_back('{x0: 32'd7,        x1: 32'd3330,     e0: 16'd7,    e1: 16'd1});
`endif

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single isolated beat, then the whole table back to back
    send(tab[0].x0, tab[0].x1, tab[0].e0, tab[0].e1);
    drain();
    for (int i = 0; i < tab.size(); i++) send(tab[i].x0, tab[i].x1, tab[i].e0, tab[i].e1);
    drain();

    // 20 back-to-back random beats
    rx_cnt = 0;
    for (int i = 0; i < 20; i++) begin
`ifdef BARRETT_MUL_EN
      r0 = {16'($urandom_range(Q - 1, 0)), 16'($urandom_range(Q - 1, 0))};
      r1 = {16'($urandom_range(Q - 1, 0)), 16'($urandom_range(Q - 1, 0))};
`else
      r0 = 32'($urandom_range(Q * Q - 1, 0));
      r1 = 32'($urandom_range(Q * Q - 1, 0));
`endif
      send(r0, r1, model(r0), model(r1));
    end
    drain();
    check("stream_count", 32'(rx_cnt), 32'd20);

    // Fill the pipe with backpressure, hold for 5 cycles, then drain
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      r0 = 32'(100 + i);
      r1 = 32'(4000 + i);
      send(r0, r1, model(r0), model(r1));
    end
    in_valid = 1'b1;
    in_data  = {32'd9999, 32'd8888};
    #1;
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_busy",      32'(busy),      32'd1);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_hold",      32'(out_data),  32'(held));
      tick();
    end
    rx_cnt = 0;
    drain();
    check("stall_drain_count", 32'(rx_cnt), 32'(LAT));
    chk_lat = 1'b1;

    // Reset with two beats in flight
    send(32'd500, 32'd600, model(32'd500), model(32'd600));
    send(32'd700, 32'd800, model(32'd700), model(32'd800));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rx_cnt = 0;
    send(tab[1].x0, tab[1].x1, tab[1].e0, tab[1].e1);
    drain();
    check("post_rst_count", 32'(rx_cnt), 32'd1);

    repeat (2) tick();
    check("idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
